alu_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU used by the quick-math datapath.
- Adds the following over the combinational ALU:
  - generic WIDTH
  - START/BUSY/DONE handshake
  - variable-distance shifts
  - a multi-cycle shift-add multiplier with double-width result
  - status flags
  - invalid-mode detection
- Sits between the operand registers and the answer checker.
- Single-cycle ops complete in 1 clock. MUL takes WIDTH clocks.

---
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with a START/BUSY/DONE handshake, status flags and a
// multi-cycle shift-add multiplier producing a double-width product.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       MODE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RES,
  output logic [WIDTH-1:0] RES_HI,
  output logic             ZERO,
  output logic             CARRY,
  output logic             NEG,
  output logic             OVF,
  output logic             ERR
);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic             mode_ok;
  logic [WIDTH-1:0] c_res;
  logic             c_carry;
  logic             c_ovf;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   sh_l;
  logic [WIDTH:0]   sh_r;

  logic [WIDTH:0]   m_sum;
  logic [WIDTH-1:0] m_hi;
  logic [WIDTH-1:0] m_lo;

  assign mode_ok = (MODE != 6'd0) &&
                   ((MODE & (MODE - 6'd1)) == 6'd0);

  // Shifts run one bit wider so the last bit out lands in the extra bit.
  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    sum_ext = '0;
    sh_l    = '0;
    sh_r    = '0;
    if (mode_ok) begin
      unique case (1'b1)
        MODE[5]: begin
          sum_ext = {1'b0, A} + {1'b0, B};
          c_res   = sum_ext[WIDTH-1:0];
          c_carry = sum_ext[WIDTH];
          c_ovf   = (A[WIDTH-1] == B[WIDTH-1]) &&
                    (c_res[WIDTH-1] != A[WIDTH-1]);
        end
        MODE[4]: begin
          sum_ext = {1'b0, A} - {1'b0, B};
          c_res   = sum_ext[WIDTH-1:0];
          c_carry = sum_ext[WIDTH];
          c_ovf   = (A[WIDTH-1] != B[WIDTH-1]) &&
                    (c_res[WIDTH-1] != A[WIDTH-1]);
        end
        MODE[3]: begin
          c_res = A ^ B;
        end
        MODE[2]: begin
          sh_l    = {1'b0, A} << B;
          c_res   = sh_l[WIDTH-1:0];
          c_carry = sh_l[WIDTH];
        end
        MODE[1]: begin
          sh_r    = {A, 1'b0} >> B;
          c_res   = sh_r[WIDTH:1];
          c_carry = sh_r[0];
        end
        MODE[0]: begin
        end
      endcase
    end
  end

  always_comb begin
    m_sum = {1'b0, acc_hi} +
            (acc_lo[0] ? {1'b0, mcand} : '0);
    m_hi  = m_sum[WIDTH:1];
    m_lo  = {m_sum[0], acc_lo[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RES    <= '0;
      RES_HI <= '0;
      ZERO   <= 1'b0;
      CARRY  <= 1'b0;
      NEG    <= 1'b0;
      OVF    <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            if (mode_ok && MODE[0]) begin
              mcand  <= A;
              acc_lo <= B;
              acc_hi <= '0;
              cnt    <= '0;
              BUSY   <= 1'b1;
              state  <= S_MUL;
            end else begin
              DONE   <= 1'b1;
              RES    <= c_res;
              RES_HI <= '0;
              ZERO   <= mode_ok && (c_res == '0);
              CARRY  <= c_carry;
              NEG    <= c_res[WIDTH-1];
              OVF    <= c_ovf;
              ERR    <= !mode_ok;
            end
          end
        end
        S_MUL: begin
          acc_hi <= m_hi;
          acc_lo <= m_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            state  <= S_IDLE;
            RES    <= m_lo;
            RES_HI <= m_hi;
            ZERO   <= ({m_hi, m_lo} == '0);
            CARRY  <= (m_hi != '0);
            NEG    <= m_lo[WIDTH-1];
            OVF    <= 1'b0;
            ERR    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random ops
// compared against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;
  localparam logic [5:0] M_ADD = 6'b100000;
  localparam logic [5:0] M_SUB = 6'b010000;
  localparam logic [5:0] M_XOR = 6'b001000;
  localparam logic [5:0] M_SHL = 6'b000100;
  localparam logic [5:0] M_SHR = 6'b000010;
  localparam logic [5:0] M_MUL = 6'b000001;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [5:0]   MODE;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RES;
  logic [W-1:0] RES_HI;
  logic         ZERO;
  logic         CARRY;
  logic         NEG;
  logic         OVF;
  logic         ERR;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .A(A), .B(B), .MODE(MODE),
    .BUSY(BUSY), .DONE(DONE),
    .RES(RES), .RES_HI(RES_HI),
    .ZERO(ZERO), .CARRY(CARRY), .NEG(NEG),
    .OVF(OVF), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Expected {RES_HI, RES, ZERO, CARRY, NEG, OVF, ERR}.
  function automatic logic [20:0] model(
    input logic [7:0] a, input logic [7:0] b,
    input logic [5:0] m);
    int ia, ib, sa, sb, v, r, rh;
    logic c, o, z, n, e;
    ia = int'(a); ib = int'(b);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    r = 0; rh = 0; c = 0; o = 0; e = 0;
    if ($countones(m) != 1) e = 1;
    else case (m)
      M_ADD: begin
        v = ia + ib; r = v % 256; c = (v > 255);
        o = (sa + sb > 127) || (sa + sb < -128);
      end
      M_SUB: begin
        v = ia - ib; r = (v + 256) % 256; c = (ia < ib);
        o = (sa - sb > 127) || (sa - sb < -128);
      end
      M_XOR: r = ia ^ ib;
      M_SHL: begin
        if (ib == 0) r = ia;
        else if (ib <= 8) begin
          r = (ia * (1 << ib)) % 256;
          c = ((ia >> (8 - ib)) & 1) != 0;
        end
      end
      M_SHR: begin
        if (ib == 0) r = ia;
        else if (ib <= 8) begin
          r = ia >> ib;
          c = ((ia >> (ib - 1)) & 1) != 0;
        end
      end
      default: begin
        v = ia * ib; r = v % 256; rh = v / 256;
        c = (rh != 0);
      end
    endcase
    z = !e && (r == 0) && (rh == 0);
    n = !e && (r > 127);
    return {rh[7:0], r[7:0], z, c, n, o, e};
  endfunction

  function automatic logic [5:0] rand_invalid();
    logic [5:0] m;
    m = 6'(($urandom % 64));
    while ($countones(m) == 1) m = 6'(($urandom % 64));
    return m;
  endfunction

  function automatic logic [20:0] got();
    return {RES_HI, RES, ZERO, CARRY, NEG, OVF, ERR};
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [5:0] m);
    @(negedge CLK);
    A = a; B = b; MODE = m; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; A = '0; B = '0; MODE = M_ADD;
    #1;
    checks++;
    if ({got(), BUSY, DONE} !== 23'd0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", {got(), BUSY, DONE});
    end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({got(), BUSY, DONE} !== 23'd0) begin
      errors++;
      $display("FAIL reset_held: got %h want 0", {got(), BUSY, DONE});
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_add();
    logic [7:0] a, b;
    issue(8'hFF, 8'h01, M_ADD);
    checks++;
    if ({got(), DONE} !== {8'h00, 8'h00, 5'b11000, 1'b1}) begin
      errors++;
      $display("FAIL add_ff_01: got %h want %h",
               {got(), DONE}, {8'h00, 8'h00, 5'b11000, 1'b1});
    end
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse: got %b want 0", DONE);
    end
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      issue(a, b, M_ADD);
      checks++;
      if ({got(), DONE} !== {model(a, b, M_ADD), 1'b1}) begin
        errors++;
        $display("FAIL add_rand %h+%h: got %h want %h",
                 a, b, {got(), DONE}, {model(a, b, M_ADD), 1'b1});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [5:0] m;
    logic [5:0] ops [6];
    ops = '{M_ADD, M_SUB, M_XOR, M_SHL, M_SHR, 6'b000011};
    @(negedge CLK);
    A = 8'h80; B = 8'h01; MODE = M_SUB; START = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({got(), DONE} !== {8'h00, 8'h7F, 5'b00010, 1'b1}) begin
      errors++;
      $display("FAIL sub_80_01: got %h want %h",
               {got(), DONE}, {8'h00, 8'h7F, 5'b00010, 1'b1});
    end
    A = 8'h03; B = 8'h05;
    @(posedge CLK); #1;
    START = 1'b0;
    checks++;
    if ({got(), DONE} !== {8'h00, 8'hFE, 5'b01100, 1'b1}) begin
      errors++;
      $display("FAIL sub_03_05: got %h want %h",
               {got(), DONE}, {8'h00, 8'hFE, 5'b01100, 1'b1});
    end
    @(negedge CLK);
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      m = ops[$urandom_range(0, 5)];
      if (m == 6'b000011) m = rand_invalid();
      if (m == M_SHL || m == M_SHR) b = 8'($urandom_range(0, 11));
      A = a; B = b; MODE = m; START = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if ({got(), DONE} !== {model(a, b, m), 1'b1}) begin
        errors++;
        $display("FAIL b2b_rand m=%b a=%h b=%h: got %h want %h",
                 m, a, b, {got(), DONE}, {model(a, b, m), 1'b1});
      end
    end
    START = 1'b0;
  endtask

  task automatic test_shift();
    logic [7:0] a, b;
    logic [5:0] m;
    issue(8'h81, 8'd1, M_SHL);
    checks++;
    if ({RES, CARRY, DONE} !== {8'h02, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL shl_81_1: got %h want %h",
               {RES, CARRY, DONE}, {8'h02, 1'b1, 1'b1});
    end
    issue(8'h81, 8'd8, M_SHR);
    checks++;
    if ({RES, CARRY, ZERO} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL shr_81_8: got %h want %h",
               {RES, CARRY, ZERO}, {8'h00, 1'b1, 1'b1});
    end
    issue(8'h81, 8'd9, M_SHR);
    checks++;
    if ({RES, CARRY, ZERO} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL shr_81_9: got %h want %h",
               {RES, CARRY, ZERO}, {8'h00, 1'b0, 1'b1});
    end
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = (i % 5 == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      m = (i % 2 == 0) ? M_SHL : M_SHR;
      issue(a, b, m);
      checks++;
      if ({got(), DONE} !== {model(a, b, m), 1'b1}) begin
        errors++;
        $display("FAIL shift_rand m=%b a=%h b=%0d: got %h want %h",
                 m, a, b, {got(), DONE}, {model(a, b, m), 1'b1});
      end
    end
  endtask

  task automatic test_err();
    logic [5:0] m;
    issue(8'h12, 8'h34, 6'b000011);
    checks++;
    if ({got(), DONE} !== {8'h00, 8'h00, 5'b00001, 1'b1}) begin
      errors++;
      $display("FAIL err_000011: got %h want %h",
               {got(), DONE}, {8'h00, 8'h00, 5'b00001, 1'b1});
    end
    issue(8'h0F, 8'hFF, M_XOR);
    checks++;
    if ({got(), DONE} !== {8'h00, 8'hF0, 5'b00100, 1'b1}) begin
      errors++;
      $display("FAIL xor_after_err: got %h want %h",
               {got(), DONE}, {8'h00, 8'hF0, 5'b00100, 1'b1});
    end
    for (int i = 0; i < 6; i++) begin
      m = rand_invalid();
      issue(8'($urandom), 8'($urandom), m);
      checks++;
      if ({got(), DONE} !== {21'd1, 1'b1}) begin
        errors++;
        $display("FAIL err_rand m=%b: got %h want %h",
                 m, {got(), DONE}, {21'd1, 1'b1});
      end
    end
  endtask

  task automatic test_mul();
    logic [15:0] old;
    logic [7:0]  a, b;
    issue(8'h10, 8'h20, M_ADD);
    old = {RES_HI, RES};
    issue(8'hFF, 8'hFF, M_MUL);
    checks++;
    if ({BUSY, DONE} !== 2'b10) begin
      errors++;
      $display("FAIL mul_start: got busy/done %b want 10", {BUSY, DONE});
    end
    for (int i = 1; i <= W + 1; i++) begin
      if (i == 3) begin
        START = 1'b1; MODE = M_ADD; A = 8'h01; B = 8'h01;
      end
      @(posedge CLK); #1;
      if (i == 3) begin
        START = 1'b0; MODE = M_XOR; A = 8'h55; B = 8'hAA;
      end
      checks++;
      if (i < W) begin
        if ({BUSY, DONE, RES_HI, RES} !== {2'b10, old}) begin
          errors++;
          $display("FAIL mul_busy cyc %0d: got %h want %h",
                   i, {BUSY, DONE, RES_HI, RES}, {2'b10, old});
        end
      end else if (i == W) begin
        if ({got(), BUSY, DONE} !==
            {8'hFE, 8'h01, 5'b01000, 2'b01}) begin
          errors++;
          $display("FAIL mul_ff_ff: got %h want %h",
                   {got(), BUSY, DONE}, {8'hFE, 8'h01, 5'b01000, 2'b01});
        end
      end else begin
        if ({BUSY, DONE} !== 2'b00) begin
          errors++;
          $display("FAIL mul_done_once: got %b want 00", {BUSY, DONE});
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 8'h00 : 8'($urandom);
      b = 8'($urandom);
      issue(a, b, M_MUL);
      repeat (W - 1) @(posedge CLK);
      #1;
      checks++;
      if (DONE !== 1'b0) begin
        errors++;
        $display("FAIL mul_early_done %h*%h: got %b want 0", a, b, DONE);
      end
      @(posedge CLK); #1;
      checks++;
      if ({got(), BUSY, DONE} !== {model(a, b, M_MUL), 2'b01}) begin
        errors++;
        $display("FAIL mul_rand %h*%h: got %h want %h", a, b,
                 {got(), BUSY, DONE}, {model(a, b, M_MUL), 2'b01});
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    issue(8'($urandom), 8'($urandom), M_MUL);
    repeat (4) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if ({got(), BUSY, DONE} !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid_mul: got %h want 0", {got(), BUSY, DONE});
    end
    @(negedge CLK);
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d busy/done cycles want 0", seen);
    end
    issue(8'h02, 8'h03, M_ADD);
    checks++;
    if ({got(), DONE} !== {8'h00, 8'h05, 5'b00000, 1'b1}) begin
      errors++;
      $display("FAIL add_after_reset: got %h want %h",
               {got(), DONE}, {8'h00, 8'h05, 5'b00000, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
    test_err();
    test_mul();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
